// File: rtl/tinisoc_pkg.sv
// Shared definitions for the tinisoc memory subsystem: arbiter state encoding,
// default arbitration limits and the unified memory address width.
package tinisoc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_IM = 2'd1,
    ST_GRANT_DM = 2'd2
  } arb_state_t;

  localparam int         MEM_AW           = 12;
  localparam int         STARVE_LIMIT_DEF = 4;
  localparam int         TIMEOUT_DEF      = 15;
  localparam logic [2:0] STARVE_MAX       = 3'd7;

  // Word-to-byte conversion plus base offset; wraps modulo the memory size.
  function automatic logic [MEM_AW-1:0] im_byte_addr(input logic [9:0]        word,
                                                     input logic [MEM_AW-1:0] base);
    logic [MEM_AW-1:0] byte_addr;
    byte_addr = {2'b00, word} << 2'd2;
    return byte_addr + base;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch / data port) in front of a unified
// single-port memory, with IM anti-starvation and an access timeout.
module mem_arbiter
  import tinisoc_pkg::*;
#(
  parameter logic [MEM_AW-1:0] IM_BASE      = 12'h000,
  parameter int                STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int                TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              im_req,
  input  logic [9:0]        im_address,
  output logic [31:0]       im_rdata,
  output logic              im_ready,
  input  logic              dm_req,
  input  logic              dm_write,
  input  logic [MEM_AW-1:0] dm_address,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ready,
  output logic              mem_enable,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_address,
  output logic [31:0]       mem_in,
  input  logic [31:0]       mem_out,
  input  logic              mem_ack,
  output logic              bus_error,
  output logic              grant_dm
);

  localparam logic [31:0] STARVE_LIM = 32'(STARVE_LIMIT);
  localparam logic [7:0]  TO_LAST    = 8'(TIMEOUT - 1);

  arb_state_t        state_r;
  arb_state_t        next_state_s;
  logic [2:0]        starve_cnt_r;
  logic [7:0]        tcnt_r;
  logic              im_starved_s;

  logic              mem_enable_s;
  logic              mem_read_s;
  logic              mem_write_s;
  logic [MEM_AW-1:0] mem_address_s;
  logic [31:0]       mem_in_s;
  logic              im_ready_s;
  logic              dm_ready_s;
  logic              bus_error_s;
  logic              grant_dm_s;
  logic [31:0]       im_rdata_s;
  logic [31:0]       dm_rdata_s;

  assign im_starved_s = im_req && ({29'd0, starve_cnt_r} >= STARVE_LIM);

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state: DM priority unless IM has starved; grants end on ack or timeout
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (dm_req && !im_starved_s) begin
          next_state_s = ST_GRANT_DM;
        end else if (im_req) begin
          next_state_s = ST_GRANT_IM;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_GRANT_IM, ST_GRANT_DM: begin
        if (mem_ack || (tcnt_r == TO_LAST)) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; address/data are latched at grant entry
  always_comb begin
    mem_enable_s  = 1'b0;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    mem_address_s = mem_address;
    mem_in_s      = mem_in;
    im_ready_s    = 1'b0;
    dm_ready_s    = 1'b0;
    bus_error_s   = 1'b0;
    grant_dm_s    = 1'b0;
    im_rdata_s    = im_rdata;
    dm_rdata_s    = dm_rdata;
    case (state_r)
      ST_IDLE: begin
        case (next_state_s)
          ST_GRANT_IM: begin
            mem_enable_s  = 1'b1;
            mem_read_s    = 1'b1;
            mem_address_s = im_byte_addr(im_address, IM_BASE);
          end
          ST_GRANT_DM: begin
            mem_enable_s  = 1'b1;
            mem_read_s    = !dm_write;
            mem_write_s   = dm_write;
            mem_address_s = dm_address;
            mem_in_s      = dm_wdata;
            grant_dm_s    = 1'b1;
          end
          default: begin
            mem_enable_s = 1'b0;
          end
        endcase
      end
      ST_GRANT_IM: begin
        if (next_state_s == ST_IDLE) begin
          im_ready_s  = 1'b1;
          bus_error_s = !mem_ack;
          im_rdata_s  = mem_ack ? mem_out : 32'h0000_0000;
        end else begin
          mem_enable_s = mem_enable;
          mem_read_s   = mem_read;
          mem_write_s  = mem_write;
        end
      end
      ST_GRANT_DM: begin
        if (next_state_s == ST_IDLE) begin
          dm_ready_s  = 1'b1;
          bus_error_s = !mem_ack;
          if (mem_write) begin
            dm_rdata_s = dm_rdata;
          end else begin
            dm_rdata_s = mem_ack ? mem_out : 32'h0000_0000;
          end
        end else begin
          mem_enable_s = mem_enable;
          mem_read_s   = mem_read;
          mem_write_s  = mem_write;
          grant_dm_s   = 1'b1;
        end
      end
      default: begin
        mem_enable_s = 1'b0;
      end
    endcase
  end

  // Starvation and timeout counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= 3'd0;
      tcnt_r       <= 8'd0;
    end else begin
      if ((state_r == ST_IDLE) && (next_state_s == ST_GRANT_IM)) begin
        starve_cnt_r <= 3'd0;
      end else if (im_req && (state_r != ST_GRANT_IM) && (starve_cnt_r != STARVE_MAX)) begin
        starve_cnt_r <= starve_cnt_r + 3'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
      if ((state_r != ST_IDLE) && !mem_ack && (tcnt_r != TO_LAST)) begin
        tcnt_r <= tcnt_r + 8'd1;
      end else begin
        tcnt_r <= 8'd0;
      end
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_enable  <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_in      <= 32'h0000_0000;
      im_ready    <= 1'b0;
      dm_ready    <= 1'b0;
      bus_error   <= 1'b0;
      grant_dm    <= 1'b0;
      im_rdata    <= 32'h0000_0000;
      dm_rdata    <= 32'h0000_0000;
    end else begin
      mem_enable  <= mem_enable_s;
      mem_read    <= mem_read_s;
      mem_write   <= mem_write_s;
      mem_address <= mem_address_s;
      mem_in      <= mem_in_s;
      im_ready    <= im_ready_s;
      dm_ready    <= dm_ready_s;
      bus_error   <= bus_error_s;
      grant_dm    <= grant_dm_s;
      im_rdata    <= im_rdata_s;
      dm_rdata    <= dm_rdata_s;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a main instance (IM_BASE=0x100) and a second
// instance (IM_BASE=0xFF0) driven in lockstep to observe address wrap.
module tb_mem_arbiter;
  import tinisoc_pkg::*;

  logic        clock;
  logic        reset;
  logic        im_req;
  logic [9:0]  im_address;
  logic        dm_req;
  logic        dm_write;
  logic [11:0] dm_address;
  logic [31:0] dm_wdata;
  logic [31:0] mem_out;
  logic        mem_ack;

  logic [31:0] im_rdata, dm_rdata, mem_in;
  logic        im_ready, dm_ready, mem_enable, mem_read, mem_write, bus_error, grant_dm;
  logic [11:0] mem_address;

  logic [31:0] w_im_rdata, w_dm_rdata, w_mem_in;
  logic        w_im_ready, w_dm_ready, w_mem_enable, w_mem_read, w_mem_write, w_bus_error, w_grant_dm;
  logic [11:0] w_mem_address;

  int checks   = 0;
  int failures = 0;

  logic [11:0] seen_addr, seen_waddr;
  logic [31:0] seen_in;
  logic        seen_rd, seen_wr, seen_gdm, stable;

  mem_arbiter #(.IM_BASE(12'h100), .STARVE_LIMIT(4), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .im_req(im_req), .im_address(im_address), .im_rdata(im_rdata), .im_ready(im_ready),
    .dm_req(dm_req), .dm_write(dm_write), .dm_address(dm_address), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_enable(mem_enable), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_in(mem_in), .mem_out(mem_out), .mem_ack(mem_ack),
    .bus_error(bus_error), .grant_dm(grant_dm)
  );

  mem_arbiter #(.IM_BASE(12'hFF0), .STARVE_LIMIT(4), .TIMEOUT(15)) u_wrap (
    .clock(clock), .reset(reset),
    .im_req(im_req), .im_address(im_address), .im_rdata(w_im_rdata), .im_ready(w_im_ready),
    .dm_req(dm_req), .dm_write(dm_write), .dm_address(dm_address), .dm_wdata(dm_wdata),
    .dm_rdata(w_dm_rdata), .dm_ready(w_dm_ready),
    .mem_enable(w_mem_enable), .mem_read(w_mem_read), .mem_write(w_mem_write),
    .mem_address(w_mem_address), .mem_in(w_mem_in), .mem_out(mem_out), .mem_ack(mem_ack),
    .bus_error(w_bus_error), .grant_dm(w_grant_dm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs a granted access until a ready pulse; ack_delay<0 means never ack.
  task automatic serve(input int ack_delay, input logic [31:0] data, output int gcyc);
    gcyc    = 0;
    stable  = 1'b1;
    mem_ack = 1'b0;
    mem_out = data;
    for (int i = 0; i < 40; i++) begin
      step();
      if (im_ready || dm_ready) break;
      if (mem_enable) begin
        gcyc++;
        if (gcyc == 1) begin
          seen_addr  = mem_address;
          seen_waddr = w_mem_address;
          seen_in    = mem_in;
          seen_rd    = mem_read;
          seen_wr    = mem_write;
          seen_gdm   = grant_dm;
        end else if (mem_address != seen_addr || mem_read != seen_rd || mem_write != seen_wr) begin
          stable = 1'b0;
        end
      end
      mem_ack = (ack_delay >= 0) && (gcyc > ack_delay);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    int g;
    int im_wait;
    int dm_grants;
    logic im_granted;

    reset = 1'b0; im_req = 1'b0; im_address = 10'd0; dm_req = 1'b0; dm_write = 1'b0;
    dm_address = 12'd0; dm_wdata = 32'd0; mem_out = 32'd0; mem_ack = 1'b0;

    // Reset state without any clock edge
    #3;
    check("rst_enable", {31'd0, mem_enable}, 32'd0);
    check("rst_ready", {30'd0, im_ready, dm_ready}, 32'd0);
    check("rst_misc", {29'd0, bus_error, grant_dm, mem_write}, 32'd0);
    check("rst_addr", {20'd0, mem_address}, 32'd0);
    check("rst_rdata", im_rdata | dm_rdata | mem_in, 32'd0);
    step(); step();
    reset = 1'b1;
    step();
    check("idle_enable", {31'd0, mem_enable}, 32'd0);

    // Lone IM read
    im_req = 1'b1; im_address = 10'h005;
    serve(2, 32'hDEADBEEF, g);
    check("im_ready", {31'd0, im_ready}, 32'd1);
    check("im_rdata", im_rdata, 32'hDEADBEEF);
    check("im_addr", {20'd0, seen_addr}, 32'h114);
    check("im_strobes", {29'd0, seen_rd, seen_wr, seen_gdm}, 32'b100);
    check("im_grant_len", g, 32'd3);
    check("im_stable", {31'd0, stable}, 32'd1);
    check("im_no_err", {30'd0, bus_error, dm_ready}, 32'd0);
    im_req = 1'b0;
    step();
    check("im_pulse_1cyc", {31'd0, im_ready}, 32'd0);
    check("im_rdata_hold", im_rdata, 32'hDEADBEEF);

    // DM load
    dm_req = 1'b1; dm_write = 1'b0; dm_address = 12'h0C4;
    serve(0, 32'hCAFEF00D, g);
    check("ld_ready", {31'd0, dm_ready}, 32'd1);
    check("ld_rdata", dm_rdata, 32'hCAFEF00D);
    check("ld_strobes", {29'd0, seen_rd, seen_wr, seen_gdm}, 32'b101);
    check("ld_addr", {20'd0, seen_addr}, 32'h0C4);
    dm_req = 1'b0;
    step();

    // DM store
    dm_req = 1'b1; dm_write = 1'b1; dm_address = 12'hABC; dm_wdata = 32'h12345678;
    serve(0, 32'h5555AAAA, g);
    check("st_ready", {31'd0, dm_ready}, 32'd1);
    check("st_strobes", {29'd0, seen_rd, seen_wr, seen_gdm}, 32'b011);
    check("st_addr", {20'd0, seen_addr}, 32'hABC);
    check("st_wdata", seen_in, 32'h12345678);
    check("st_rdata_keep", dm_rdata, 32'hCAFEF00D);
    dm_req = 1'b0; dm_write = 1'b0;
    step();
    check("st_grant_off", {30'd0, grant_dm, mem_enable}, 32'd0);

    // Starvation: IM held while DM keeps re-requesting
    im_req = 1'b1; im_address = 10'h001; dm_req = 1'b1; dm_address = 12'h020;
    im_wait = 0; dm_grants = 0; im_granted = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      im_wait++;
      if (mem_enable && !grant_dm) begin
        im_granted = 1'b1;
        break;
      end
      if (mem_enable && grant_dm) dm_grants++;
      mem_ack = grant_dm;
    end
    check("starve_granted", {31'd0, im_granted}, 32'd1);
    check("starve_wait_le5", {31'd0, (im_wait - 1) <= 5}, 32'd1);
    check("starve_dm_grants", dm_grants, 32'd2);
    check("starve_cnt_clr", {29'd0, dut.starve_cnt_r}, 32'd0);
    dm_req = 1'b0; mem_ack = 1'b1; mem_out = 32'h0000_1111;
    step();
    check("starve_im_done", {30'd0, im_ready, dm_ready}, 32'b10);
    check("starve_im_rdata", im_rdata, 32'h0000_1111);
    im_req = 1'b0; mem_ack = 1'b0;
    step();

    // Timeout on DM load
    dm_req = 1'b1; dm_write = 1'b0; dm_address = 12'h010;
    serve(-1, 32'hFFFFFFFF, g);
    check("to_grant_len", g, 32'd15);
    check("to_ready_err", {30'd0, dm_ready, bus_error}, 32'b11);
    check("to_rdata_zero", dm_rdata, 32'd0);
    dm_req = 1'b0;
    step();
    check("to_pulse_1cyc", {29'd0, dm_ready, bus_error, mem_enable}, 32'd0);
    check("to_idle", {30'd0, dut.state_r}, {30'd0, ST_IDLE});

    // Ack on the timeout cycle is a success
    im_req = 1'b1; im_address = 10'h002;
    serve(14, 32'h0BADF00D, g);
    check("toack_len", g, 32'd15);
    check("toack_ready", {30'd0, im_ready, bus_error}, 32'b10);
    check("toack_rdata", im_rdata, 32'h0BADF00D);
    im_req = 1'b0;
    step();

    // Reset two cycles into an IM grant
    im_req = 1'b1; im_address = 10'h007;
    step(); step();
    check("rg_in_grant", {31'd0, mem_enable}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rg_strobes_drop", {29'd0, mem_enable, mem_read, grant_dm}, 32'd0);
    check("rg_addr_clr", {20'd0, mem_address}, 32'd0);
    step(); step();
    check("rg_no_ready", {30'd0, im_ready, dm_ready}, 32'd0);
    reset = 1'b1;
    serve(0, 32'h600DCAFE, g);
    check("rg_resume_ready", {31'd0, im_ready}, 32'd1);
    check("rg_resume_rdata", im_rdata, 32'h600DCAFE);
    check("rg_resume_addr", {20'd0, seen_addr}, 32'h11C);
    im_req = 1'b0;
    step();

    // Address wrap modulo 4096
    im_req = 1'b1; im_address = 10'h3FF;
    serve(0, 32'h0000_0001, g);
    check("wrap_main", {20'd0, seen_addr}, 32'h0FC);
    check("wrap_ff0", {20'd0, seen_waddr}, 32'hFEC);
    im_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
